// File: rtl/rk16_intc.sv
// rk16_intc - interrupt controller for the RK16 core.
//
// Latches rising edges on NSRC external lines into PEND. It applies a
// per-source MASK and a global enable (GIE), and requests the
// lowest-numbered eligible source on `intr`. The request is held until the
// PC stage takes the jump (pc_en). No new request is raised until the
// handler returns (iret).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   src        interrupt lines; a rising edge requests service
//   pc_en      instruction boundary; accepts a pending request
//   iret       one-cycle return-from-interrupt pulse
//   intr       registered interrupt request to the PC stage
//   cfg_we     config write strobe
//   cfg_addr   config register select (0 CTRL, 1 PEND, 2 CAUSE, 3 zero)
//   cfg_wdata  config write data
//   cfg_rdata  config read data, combinational from cfg_addr
module rk16_intc #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  input  logic            pc_en,
  input  logic            iret,
  output logic            intr,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic [15:0]     cfg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [NSRC-1:0] src_q_reg;
  logic [NSRC-1:0] pend_reg, pend_next;
  logic [NSRC-1:0] mask_reg;
  logic            gie_reg;
  logic            armed_reg;
  logic            intr_reg;
  logic            in_svc_reg, in_svc_next;
  logic [3:0]      sel_reg, sel_next;
  logic [3:0]      cause_reg, cause_next;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] acc_clr;
  logic [3:0]      first_id;
  logic            any_elig;
  logic            accept;
  logic            wr_ctrl;
  logic            wr_pend;

  // Write data bits above the implemented fields are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  assign wr_ctrl = cfg_we && (cfg_addr == 2'd0);
  assign wr_pend = cfg_we && (cfg_addr == 2'd1);
  assign accept  = (state_reg == ST_REQ) && pc_en;

  // armed_reg stays low for the first cycle after reset. src_q then loads
  // the live src value without seeing a level held through reset as an edge.
  assign rise = armed_reg ? (src & ~src_q_reg) : '0;
  assign elig = gie_reg ? (pend_reg & mask_reg) : '0;
  assign any_elig = |elig;

  // Lowest-numbered eligible source wins.
  always_comb begin
    first_id = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        first_id = 4'(i);
      end
    end
  end

  // Per-bit PEND update. A new edge beats any clear of the same bit.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
      assign w1c[gi]       = wr_pend & cfg_wdata[gi];
      assign acc_clr[gi]   = accept && (sel_reg == 4'(gi));
      assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~w1c[gi] & ~acc_clr[gi]);
    end
  endgenerate

  // Request FSM. Once in REQ the request is committed: config changes cannot
  // withdraw it, only pc_en moves on.
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    cause_next  = cause_reg;
    in_svc_next = in_svc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_elig) begin
          sel_next   = first_id;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (pc_en) begin
          cause_next  = sel_reg;
          in_svc_next = 1'b1;
          state_next  = ST_SVC;
        end
      end
      ST_SVC: begin
        if (iret) begin
          in_svc_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      src_q_reg  <= '0;
      pend_reg   <= '0;
      mask_reg   <= '0;
      gie_reg    <= 1'b0;
      armed_reg  <= 1'b0;
      intr_reg   <= 1'b0;
      in_svc_reg <= 1'b0;
      sel_reg    <= 4'd0;
      cause_reg  <= 4'd0;
    end else begin
      state_reg  <= state_next;
      src_q_reg  <= src;
      pend_reg   <= pend_next;
      armed_reg  <= 1'b1;
      intr_reg   <= (state_next == ST_REQ);
      in_svc_reg <= in_svc_next;
      sel_reg    <= sel_next;
      cause_reg  <= cause_next;
      if (wr_ctrl) begin
        gie_reg  <= cfg_wdata[15];
        mask_reg <= cfg_wdata[NSRC-1:0];
      end
    end
  end

  assign intr = intr_reg;

  always_comb begin
    cfg_rdata = 16'd0;
    case (cfg_addr)
      2'd0: begin
        cfg_rdata[15]       = gie_reg;
        cfg_rdata[NSRC-1:0] = mask_reg;
      end
      2'd1: begin
        cfg_rdata[NSRC-1:0] = pend_reg;
      end
      2'd2: begin
        cfg_rdata[15]  = in_svc_reg;
        cfg_rdata[3:0] = cause_reg;
      end
      default: begin
        cfg_rdata = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_rk16_intc.sv
// Testbench for rk16_intc. The driver applies directed scenarios and then
// random cycles. For every cycle it pushes the expected intr/cfg_rdata,
// taken from a behavioural model, into a queue. A monitor pops each entry
// on the falling edge and compares it with the DUT outputs.
module tb_rk16_intc;

  localparam int NSRC = 8;
  localparam int ALL  = (1 << NSRC) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] src = '0;
  logic            pc_en = 1'b0;
  logic            iret = 1'b0;
  logic            intr;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_addr = 2'd0;
  logic [15:0]     cfg_wdata = 16'd0;
  logic [15:0]     cfg_rdata;

  rk16_intc #(.NSRC(NSRC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .pc_en     (pc_en),
    .iret      (iret),
    .intr      (intr),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        intr;
    logic [15:0] rdata;
    logic [1:0]  addr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;

  // Reference model. phase: 0 waiting, 1 requesting, 2 handler running.
  int m_pend, m_mask, m_gie, m_phase, m_sel, m_cause, m_insvc, m_prev, m_fresh;

  function automatic int lowest(input int v);
    for (int i = 0; i < NSRC; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [15:0] model_read(input logic [1:0] a);
    int v;
    case (a)
      2'd0:    v = (m_gie << 15) | m_mask;
      2'd1:    v = m_pend;
      2'd2:    v = (m_insvc << 15) | m_cause;
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  task automatic model_step(input logic r, input int s, input logic pe, input logic ir,
                            input logic we, input logic [1:0] a, input int wd);
    int rise, clr, elig;
    if (!r) begin
      m_pend = 0; m_mask = 0; m_gie = 0; m_phase = 0; m_sel = 0;
      m_cause = 0; m_insvc = 0; m_prev = 0; m_fresh = 1;
      return;
    end
    rise = m_fresh ? 0 : (s & ~m_prev & ALL);
    m_prev = s;
    m_fresh = 0;
    clr = 0;
    if (m_phase == 0) begin
      elig = (m_gie != 0) ? (m_pend & m_mask) : 0;
      if (elig != 0) begin
        m_sel = lowest(elig);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (pe) begin
        clr = clr | (1 << m_sel);
        m_cause = m_sel;
        m_insvc = 1;
        m_phase = 2;
      end
    end else begin
      if (ir) begin
        m_insvc = 0;
        m_phase = 0;
      end
    end
    if (we && a == 2'd1) clr = clr | (wd & ALL);
    if (we && a == 2'd0) begin
      m_gie = (wd >> 15) & 1;
      m_mask = wd & ALL;
    end
    m_pend = (m_pend & ~clr) | rise;
  endtask

  // Driver: one call per clock. Inputs change 1 time unit after the rising
  // edge. The expectation for the current post-edge state is queued, and
  // then the model advances over the edge the new inputs will be sampled at.
  logic [NSRC-1:0] cur_src = '0;

  task automatic cyc(input logic r, input logic pe, input logic ir, input logic we,
                     input logic [1:0] wa, input logic [15:0] wd, input logic chk);
    exp_t e;
    logic [1:0] a;
    @(posedge clk);
    #1;
    a = we ? wa : 2'($urandom_range(3));
    rst_n = r; src = cur_src; pc_en = pe; iret = ir;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    cyc_no++;
    if (chk) begin
      e.intr  = (m_phase == 1);
      e.rdata = model_read(a);
      e.addr  = a;
      e.cyc   = cyc_no;
      exp_q.push_back(e);
    end
    model_step(r, int'(cur_src), pe, ir, we, a, int'(wd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, a, d, 1'b1);
  endtask

  task automatic pce();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
  endtask

  task automatic ret();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b1);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (intr !== e.intr) begin
        bad++;
        $display("FAIL intr cyc=%0d got=%0b want=%0b", e.cyc, intr, e.intr);
      end
      total++;
      if (cfg_rdata !== e.rdata) begin
        bad++;
        $display("FAIL rdata cyc=%0d addr=%0d got=0x%04h want=0x%04h",
                 e.cyc, e.addr, cfg_rdata, e.rdata);
      end
    end
  end

  initial begin
    logic [15:0] wd;
    logic        r;
    // Reset; the DUT state is unknown before the first edge, so the
    // first cycle is not checked.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
    idle(2);

    // Basic single-source request, accept, return.
    wr(2'd0, 16'h8001);
    idle(2);
    cur_src = 8'h01; idle(1);
    idle(2);
    pce();
    idle(2);
    ret();
    cur_src = 8'h00; idle(2);

    // Priority between two simultaneous edges.
    wr(2'd0, 16'h80FF);
    cur_src = 8'h24; idle(1);
    idle(2);
    pce();
    idle(2);
    ret();
    idle(3);
    pce();
    idle(1);
    ret();
    cur_src = 8'h00; idle(2);

    // Masked source stays pending until unmasked.
    wr(2'd0, 16'h8000);
    cur_src = 8'h08; idle(1);
    idle(20);
    wr(2'd0, 16'h8008);
    idle(2);
    pce();
    ret();
    cur_src = 8'h00; idle(2);

    // Committed request survives GIE being cleared.
    wr(2'd0, 16'h8001);
    cur_src = 8'h01; idle(1);
    idle(1);
    wr(2'd0, 16'h0000);
    idle(3);
    pce();
    idle(1);
    ret();
    cur_src = 8'h00; idle(1);
    cur_src = 8'h01; idle(5);
    cur_src = 8'h00; idle(1);

    // W1C racing a new edge on the same bit; iret while idle.
    wr(2'd1, 16'h00FF);
    wr(2'd0, 16'h0001);
    cur_src = 8'h01;
    wr(2'd1, 16'h0001);
    idle(2);
    ret();
    idle(2);
    cur_src = 8'h00; idle(1);

    // Reset in the middle of servicing, with sources held high throughout.
    wr(2'd1, 16'h00FF);
    wr(2'd0, 16'h80FF);
    cur_src = 8'h10; idle(1);
    idle(2);
    pce();
    idle(2);
    cur_src = 8'hFF;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
    idle(6);
    cur_src = 8'h00; idle(2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(7) == 0) cur_src[i] = ~cur_src[i];
      end
      wd = 16'($urandom);
      if ($urandom_range(4) != 0) wd[15] = 1'b1;
      r = ($urandom_range(299) != 0);
      cyc(r, 1'($urandom_range(1)), ($urandom_range(9) == 0),
          ($urandom_range(9) == 0), 2'($urandom_range(3)), wd, 1'b1);
    end

    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rk16_intc.md
# rk16_intc

Interrupt controller for the RK16 core; sits directly upstream of the program-flow-control stage and generates its `intr` request. Latches rising edges on eight external sources, applies a per-source mask and global enable, selects the lowest-numbered pending source, holds `intr` until the PC stage commits the jump, then blocks further requests until the handler returns. Exposes mask, pending and cause registers on a small config port driven by the core's CSR/IO path.

## Interface

- `NSRC`, default 8: number of interrupt sources, range 1..15.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `src` input NSRC: interrupt lines, synchronous to `clk`; rising edge requests.
- `pc_en` input 1: high in cycles where the PC stage updates `pc`, i.e. instruction boundary.
- `iret` input 1: one-cycle pulse when the core executes return-from-interrupt.
- `intr` output 1: interrupt request to the PC stage; registered.
- `cfg_we` input 1: config write strobe.
- `cfg_addr` input 2: config register select.
- `cfg_wdata` input 16: config write data.
- `cfg_rdata` output 16: config read data; combinational from `cfg_addr`.

## Operation

- Registers:
  - addr 0 CTRL: bit15 GIE, bits NSRC-1:0 MASK; read/write.
  - addr 1 PEND: bits NSRC-1:0 pending; read; write-1-to-clear.
  - addr 2 CAUSE: bit15 in-service, bits 3:0 id of accepted source; read-only.
  - addr 3: reads 0; writes ignored.
  - Unused bits read 0.
- Edge detect: `src_q` holds the previous `src`. `src & ~src_q` sets PEND bits.
  - Set wins over a same-cycle W1C clear or acceptance clear of the same bit.
- Eligibility: `elig = PEND & MASK`, qualified by GIE. Selected id is the lowest set bit of `elig`.
- FSM:
  - IDLE: if GIE and `elig != 0`, latch id into `sel`, go to REQ, `intr <= 1`.
  - REQ: `intr` held high. On a cycle with `pc_en = 1`:
    - `intr <= 0`
    - clear PEND[`sel`]
    - CAUSE id <= `sel`, in-service <= 1
    - go to SVC
  - REQ is committed. Clearing GIE, MASK or PEND while in REQ does not withdraw `intr`.
  - SVC: no new request. On `iret`: in-service <= 0, go to IDLE.
  - `iret` in IDLE or REQ is ignored.
- Sources keep latching into PEND in every state.
- Config writes take effect at the same edge as `cfg_we`.
- No nesting. A single in-service level only.

## Timing

- Reset (`rst_n = 0` at an edge):
  - state IDLE, `intr = 0`, CTRL = 0, PEND = 0, CAUSE = 0, `src_q = 0`.
  - Reset overrides everything, including mid-REQ and mid-SVC.
- Sources held high through reset produce no edge, because `src_q` loads from `src` in the first cycle after reset.
- `src` rises, sampled at edge E: PEND set after E; `intr` high after E+1 (latency 2) if GIE and MASK are set.
- `intr` falls after the first edge with `pc_en = 1` while in REQ. Minimum high time is 1 cycle.
- `iret` sampled at edge K returns the FSM to IDLE. The earliest re-assertion of `intr` is after K+1.
- A W1C write to PEND in IDLE at edge E, with no new edge arriving, prevents the request from edge E+1 onward.

## Test plan

- Basic: CTRL = 0x8001; `src[0]` 0→1 at edge 10. Expect PEND = 0x0001 after edge 10, `intr` = 1 after edge 11. Assert `pc_en` at edge 13: `intr` = 0, PEND = 0, CAUSE = 0x8000.
- Priority: CTRL = 0x80FF; `src[5]` and `src[2]` rise in the same cycle. Expect CAUSE = 0x8002 after acceptance and PEND = 0x0020. Pulse `iret`: second request follows with CAUSE = 0x8005.
- Masking: CTRL = 0x8000; `src[3]` rises. Expect PEND = 0x0008 and `intr` stays 0 for 20 cycles. Write CTRL = 0x8008: `intr` = 1 on the next cycle.
- Committed request: in REQ, write CTRL = 0x0000. Expect `intr` to stay 1 until `pc_en`, then state SVC. `iret` returns to IDLE, and no further request occurs while GIE = 0.
- W1C vs set race: write PEND = 0x0001 in the same cycle `src[0]` rises. Expect PEND bit 0 = 1. Separately, `iret` in IDLE leaves CAUSE unchanged.
- Reset mid-SVC: CAUSE = 0x8004; drive `rst_n = 0` for 1 cycle. Expect all outputs/registers 0. Hold `src = 0xFF` through reset and 5 cycles after: PEND stays 0.
